// File: rtl/decimal_entry_pkg.sv
// Shared types and constants for the keypad decimal entry path.
package decimal_entry_pkg;

    localparam int unsigned DIGITS  = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;
    localparam int unsigned ACC_W   = 14;

    typedef enum logic [1:0] {
        StEntry,
        StConvert,
        StDone
    } state_e;

endpackage

// File: rtl/bcd_mac10.sv
// Combinational decimal multiply-accumulate step: acc*10 + digit.
module bcd_mac10
    import decimal_entry_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] result
);

    // acc*10 as a shift-add pair; 9999 max fits in ACC_W so no overflow.
    assign result = (acc << 3) + (acc << 1) + ACC_W'(digit);

endmodule

// File: rtl/decimal_entry.sv
// Collects up to DIGITS BCD keys plus a sign and converts them serially to a
// 16-bit two's-complement value for the processor input port.
module decimal_entry
    import decimal_entry_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  digit_valid,
    input  logic [3:0]            digit,
    input  logic                  neg_key,
    input  logic                  enter,
    input  logic                  clear,
    output logic                  busy,
    output logic [15:0]           value,
    output logic                  value_valid,
    output logic [4*DIGITS-1:0]   entry_bcd,
    output logic                  entry_neg
);

    localparam int unsigned CNT_W = $clog2(DIGITS + 1);
    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CountMax = CNT_W'(DIGITS);
    localparam logic [IDX_W-1:0] IdxTop   = IDX_W'(DIGITS - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  neg_q, neg_d;
    logic [15:0]           value_q, value_d;
    logic                  vv_q, vv_d;
    logic                  busy_q, busy_d;

    logic [3:0]            cur_digit;
    logic [ACC_W-1:0]      mac_out;
    logic [15:0]           mag;

    assign cur_digit = bcd_q[{index_q, 2'b00} +: 4];
    assign mag       = 16'(mac_out);

    bcd_mac10 u_mac (
        .acc    (acc_q),
        .digit  (cur_digit),
        .result (mac_out)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        value_d = value_q;
        vv_d    = 1'b0;

        unique case (state_q)
            StEntry: begin
                if (clear) begin
                    bcd_d   = '0;
                    neg_d   = 1'b0;
                    count_d = '0;
                end else if (enter) begin
                    state_d = StConvert;
                    acc_d   = '0;
                    index_d = IdxTop;
                end else if (neg_key) begin
                    neg_d = ~neg_q;
                end else if (digit_valid && (digit <= BCD_MAX) && (count_q < CountMax)) begin
                    bcd_d   = {bcd_q[4*DIGITS-5:0], digit};
                    count_d = count_q + CNT_W'(1);
                end
            end
            StConvert: begin
                acc_d   = mac_out;
                index_d = index_q - IDX_W'(1);
                // Result is registered on the last iteration so it is visible in DONE.
                if (index_q == '0) begin
                    state_d = StDone;
                    value_d = neg_q ? 16'(-mag) : mag;
                    vv_d    = 1'b1;
                end
            end
            StDone: begin
                state_d = StEntry;
                bcd_d   = '0;
                neg_d   = 1'b0;
                count_d = '0;
            end
            default: state_d = StEntry;
        endcase

        busy_d = (state_d != StEntry);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StEntry;
            count_q <= '0;
            index_q <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            value_q <= '0;
            vv_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            value_q <= value_d;
            vv_q    <= vv_d;
            busy_q  <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign value       = value_q;
    assign value_valid = vv_q;
    assign entry_bcd   = bcd_q;
    assign entry_neg   = neg_q;

endmodule

// File: tb/tb_decimal_entry.sv
// Self-checking bench for decimal_entry: integer-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_decimal_entry;

    logic        clock = 1'b0;
    logic        reset;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        neg_key;
    logic        enter;
    logic        clear;
    logic        busy;
    logic [15:0] value;
    logic        value_valid;
    logic [15:0] entry_bcd;
    logic        entry_neg;

    decimal_entry #(.DIGITS(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .digit_valid (digit_valid),
        .digit       (digit),
        .neg_key     (neg_key),
        .enter       (enter),
        .clear       (clear),
        .busy        (busy),
        .value       (value),
        .value_valid (value_valid),
        .entry_bcd   (entry_bcd),
        .entry_neg   (entry_neg)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: the entry is a plain integer plus digit count; a busy
    // window counts down the cycles until the result is published.
    int          m_num = 0;
    int          m_ndig = 0;
    int          m_cnt = 0;
    bit          m_neg = 1'b0;
    bit          m_vv = 1'b0;
    logic [15:0] m_value = '0;
    logic [15:0] m_result = '0;

    function automatic logic [15:0] to_bcd(int n);
        return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_num = 0; m_ndig = 0; m_neg = 1'b0; m_cnt = 0; m_vv = 1'b0; m_value = '0;
        end else if (m_cnt > 0) begin
            m_vv = 1'b0;
            m_cnt--;
            if (m_cnt == 1) begin
                m_value = m_result;
                m_vv = 1'b1;
            end
            if (m_cnt == 0) begin
                m_num = 0; m_ndig = 0; m_neg = 1'b0;
            end
        end else begin
            m_vv = 1'b0;
            if (clear) begin
                m_num = 0; m_ndig = 0; m_neg = 1'b0;
            end else if (enter) begin
                m_result = 16'(m_neg ? -m_num : m_num);
                m_cnt = 5;
            end else if (neg_key) begin
                m_neg = !m_neg;
            end else if (digit_valid && digit <= 4'd9 && m_ndig < 4) begin
                m_num = m_num * 10 + int'(digit);
                m_ndig++;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("busy", {31'b0, busy}, {31'b0, m_cnt > 0});
            check("value", {16'b0, value}, {16'b0, m_value});
            check("value_valid", {31'b0, value_valid}, {31'b0, m_vv});
            check("entry_bcd", {16'b0, entry_bcd}, {16'b0, to_bcd(m_num)});
            check("entry_neg", {31'b0, entry_neg}, {31'b0, m_neg});
        end
    end

    // Callers are positioned 2ns after a rising edge.
    task automatic step(bit dv, logic [3:0] d, bit ng, bit en, bit cl);
        digit_valid = dv; digit = d; neg_key = ng; enter = en; clear = cl;
        @(posedge clock); #2;
        digit_valid = 1'b0; digit = 4'd0; neg_key = 1'b0; enter = 1'b0; clear = 1'b0;
    endtask

    task automatic key(logic [3:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_entry(string name, logic [15:0] bcd, bit neg);
        @(negedge clock);
        check({name, " entry_bcd"}, {16'b0, entry_bcd}, {16'b0, bcd});
        check({name, " entry_neg"}, {31'b0, entry_neg}, {31'b0, neg});
        @(posedge clock); #2;
    endtask

    task automatic conv(string name, logic [15:0] exp);
        int          vv_at = -1;
        int          busy_n = 0;
        logic [15:0] got = 'x;
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (busy) busy_n++;
            if (value_valid && vv_at < 0) begin
                vv_at = i;
                got = value;
            end
        end
        check({name, " latency"}, 32'(vv_at), 32'd5);
        check({name, " value"}, {16'b0, got}, {16'b0, exp});
        check({name, " busy cycles"}, 32'(busy_n), 32'd5);
        @(posedge clock); #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    initial begin
        int vv_seen;
        reset = 1'b1;
        digit_valid = 1'b0; digit = 4'd0; neg_key = 1'b0; enter = 1'b0; clear = 1'b0;
        @(posedge clock); #2;
        chk_en = 1'b1;
        @(negedge clock);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset value", {16'b0, value}, 32'd0);
        check("reset value_valid", {31'b0, value_valid}, 32'd0);
        check("reset entry_bcd", {16'b0, entry_bcd}, 32'd0);
        check("reset entry_neg", {31'b0, entry_neg}, 32'd0);
        @(posedge clock); #2;
        reset = 1'b0;

        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        expect_entry("t1", 16'h1234, 1'b0);
        conv("t1", 16'h04D2);

        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        key(4'd9); key(4'd9); key(4'd9); key(4'd9);
        expect_entry("t2", 16'h9999, 1'b1);
        conv("t2", 16'hD8F1);
        expect_entry("t2 after", 16'h0000, 1'b0);

        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        expect_entry("t3", 16'h1234, 1'b0);
        conv("t3", 16'h04D2);

        key(4'hC);
        expect_entry("t4 illegal", 16'h0000, 1'b0);
        key(4'd7);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        expect_entry("t4", 16'h0007, 1'b1);
        conv("t4", 16'hFFF9);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        conv("t4 negzero", 16'h0000);

        key(4'd4); key(4'd2);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clock);
        check("t5 busy after clear+enter", {31'b0, busy}, 32'd0);
        check("t5 entry after clear+enter", {16'b0, entry_bcd}, 32'd0);
        @(posedge clock); #2;
        conv("t5 empty", 16'h0000);

        key(4'd8); key(4'd8);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clock); #2;
        reset = 1'b1;
        @(posedge clock); #2;
        reset = 1'b0;
        vv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (value_valid) vv_seen++;
            if (i == 0) begin
                check("t6 value after reset", {16'b0, value}, 32'd0);
                check("t6 busy after reset", {31'b0, busy}, 32'd0);
            end
        end
        check("t6 no value_valid", 32'(vv_seen), 32'd0);
        @(posedge clock); #2;
        key(4'd5);
        expect_entry("t6 key after reset", 16'h0005, 1'b0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
